// File: rtl/q_learn_pkg.sv
`default_nettype none
// ============================================================================
// Module      : q_learn_pkg
// Description : Shared constants, FSM state encoding and Q-RAM address helper
//               for the iterative maze Q-learning sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package q_learn_pkg;

    localparam int S_W       = 6;   // maze state width
    localparam int A_W       = 3;   // action port width
    localparam int Q_W       = 32;  // signed Q value width
    localparam int N_ACTIONS = 4;   // fixed by the 2-bit action field of the address

    // Sequencer phases, one per stage of a learning step
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RD_CUR = 3'd1,
        ST_ENV    = 3'd2,
        ST_RD_NXT = 3'd3,
        ST_UPD    = 3'd4,
        ST_WR     = 3'd5,
        ST_CHK    = 3'd6,
        ST_DONE   = 3'd7
    } fsm_state_e;

    // Q-table address: the action occupies the two low bits of each state row
    function automatic logic [S_W+1:0] q_addr(input logic [S_W-1:0] state,
                                              input logic [1:0]     action);
        return {state, action};
    endfunction

endpackage
`default_nettype wire

// File: rtl/q_learn_ctrl_argmax.sv
`default_nettype none
// ============================================================================
// Module      : q_argmax
// Description : Streaming signed max / argmax accumulator. One element per
//               valid cycle; clr marks the first element of a new row. Strict
//               greater-than keeps the lowest index on ties. The *_nxt outputs
//               include the element presented this cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module q_argmax
    import q_learn_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    input  logic           clr,
    input  logic           vld,
    input  logic [1:0]     idx,
    input  logic [Q_W-1:0] din,
    output logic [Q_W-1:0] max_nxt,
    output logic [1:0]     idx_nxt
);

    logic [Q_W-1:0] max_q, max_d;
    logic [1:0]     arg_q, arg_d;

    // Replace the running best on the first element or a strictly larger one
    always_comb begin
        max_d = max_q;
        arg_d = arg_q;
        if (vld && (clr || ($signed(din) > $signed(max_q)))) begin
            max_d = din;
            arg_d = idx;
        end
    end

    assign max_nxt = max_d;
    assign idx_nxt = arg_d;

    // Running best value and its index
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            max_q <= '0;
            arg_q <= '0;
        end else begin
            max_q <= max_d;
            arg_q <= arg_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/q_learn_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : q_learn_ctrl
// Description : Iterative Q-learning step sequencer. Reads the current Q row,
//               picks an action, queries the environment, reads the next row
//               for max Q, drives the shared update datapath and writes back.
//               Optional macro Q_LEARN_EXPLORE_EN adds LFSR-driven exploration.
// Revision    : 1.0 - initial release
// ============================================================================
module q_learn_ctrl
    import q_learn_pkg::*;
#(
    parameter int N_EPISODES = 100,
    parameter int MAX_STEPS  = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic [S_W-1:0]   start_state,
    input  logic [S_W-1:0]   target_state,
    output logic [S_W+1:0]   q_addr,
    output logic             q_rd_en,
    output logic             q_wr_en,
    input  logic [Q_W-1:0]   q_rdata,
    output logic [Q_W-1:0]   q_wdata,
    output logic             env_req,
    output logic [S_W-1:0]   env_state,
    output logic [A_W-1:0]   env_action,
    input  logic             env_ack,
    input  logic [S_W-1:0]   env_next_state,
    input  logic [Q_W-1:0]   env_reward,
    output logic             upd_req,
    output logic [Q_W-1:0]   upd_old_q,
    output logic [Q_W-1:0]   upd_max_q,
    output logic [Q_W-1:0]   upd_reward,
    input  logic             upd_ack,
    input  logic [Q_W-1:0]   upd_new_q,
    output logic             busy,
    output logic             done,
    output logic [6:0]       episode_cnt,
    output logic [A_W-1:0]   final_action,
    output logic [S_W-1:0]   final_maze_state
);

    localparam int STEP_W = (MAX_STEPS > 1) ? $clog2(MAX_STEPS) : 1;

    fsm_state_e       state_q, state_d;
    logic [2:0]       rd_cnt_q, rd_cnt_d;
    logic [S_W-1:0]   cur_q, cur_d, nxt_q, nxt_d;
    logic [S_W-1:0]   start_q, start_d, tgt_q, tgt_d;
    logic [S_W-1:0]   fstate_q, fstate_d;
    logic [1:0]       act_q, act_d, fact_q, fact_d;
    logic [Q_W-1:0]   oldv_q, oldv_d, maxv_q, maxv_d;
    logic [Q_W-1:0]   rew_q, rew_d, newv_q, newv_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic [6:0]       ep_q, ep_d;
    logic             busy_q, busy_d, done_q, done_d;

    logic             rd_phase, rd_issue, rd_last;
    logic             am_vld, am_clr;
    logic [1:0]       am_idx, am_idx_nxt;
    logic [Q_W-1:0]   am_max_nxt;
    logic [1:0]       sel_act;
    logic [Q_W-1:0]   sel_old;
    logic             ep_end;

    // Read phases: cycles 0..3 issue reads, cycles 1..4 consume the data
    assign rd_phase = (state_q == ST_RD_CUR) || (state_q == ST_RD_NXT);
    assign rd_issue = rd_phase && (rd_cnt_q < 3'd4);
    assign rd_last  = rd_phase && (rd_cnt_q == 3'd4);
    assign am_vld   = rd_phase && (rd_cnt_q != 3'd0);
    assign am_clr   = (rd_cnt_q == 3'd1);
    assign am_idx   = rd_cnt_q[1:0] - 2'd1;

    q_argmax u_argmax (
        .clk     (clk),
        .rst     (rst),
        .clr     (am_clr),
        .vld     (am_vld),
        .idx     (am_idx),
        .din     (q_rdata),
        .max_nxt (am_max_nxt),
        .idx_nxt (am_idx_nxt)
    );

`ifdef Q_LEARN_EXPLORE_EN
    logic [15:0]    lfsr_q, lfsr_d;
    logic [Q_W-1:0] expl_q, expl_d;
    logic           explore;

    assign explore = (lfsr_q[3:0] == 4'd0);

    // Track the Q value of the exploration candidate; advance the LFSR once per action choice
    always_comb begin
        lfsr_d = lfsr_q;
        expl_d = expl_q;
        if ((state_q == ST_RD_CUR) && am_vld && (am_idx == lfsr_q[5:4])) begin
            expl_d = q_rdata;
        end
        if ((state_q == ST_RD_CUR) && rd_last) begin
            lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        end
    end

    // Exploration LFSR and candidate value registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr_q <= 16'hACE1;
            expl_q <= '0;
        end else begin
            lfsr_q <= lfsr_d;
            expl_q <= expl_d;
        end
    end

    assign sel_act = explore ? lfsr_q[5:4] : am_idx_nxt;
    assign sel_old = explore ? expl_d      : am_max_nxt;
`else
    assign sel_act = am_idx_nxt;
    assign sel_old = am_max_nxt;
`endif

    assign ep_end = (nxt_q == tgt_q) || (step_q == STEP_W'(MAX_STEPS - 1));

    // Step sequencer next-state and datapath register updates
    always_comb begin
        state_d  = state_q;
        rd_cnt_d = rd_cnt_q;
        cur_d    = cur_q;
        nxt_d    = nxt_q;
        start_d  = start_q;
        tgt_d    = tgt_q;
        fstate_d = fstate_q;
        act_d    = act_q;
        fact_d   = fact_q;
        oldv_d   = oldv_q;
        maxv_d   = maxv_q;
        rew_d    = rew_q;
        newv_d   = newv_q;
        step_d   = step_q;
        ep_d     = ep_q;
        busy_d   = busy_q;
        done_d   = done_q;
        unique case (state_q)
            ST_IDLE: begin
                if (rdy) begin
                    start_d  = start_state;
                    tgt_d    = target_state;
                    cur_d    = start_state;
                    step_d   = '0;
                    ep_d     = '0;
                    rd_cnt_d = '0;
                    busy_d   = 1'b1;
                    done_d   = 1'b0;
                    state_d  = ST_RD_CUR;
                end
            end
            ST_RD_CUR: begin
                rd_cnt_d = rd_cnt_q + 3'd1;
                if (rd_last) begin
                    rd_cnt_d = '0;
                    act_d    = sel_act;
                    oldv_d   = sel_old;
                    state_d  = ST_ENV;
                end
            end
            ST_ENV: begin
                if (env_ack) begin
                    nxt_d = env_next_state;
                    rew_d = env_reward;
                    // A terminal next state contributes no future value
                    if (env_next_state == tgt_q) begin
                        maxv_d  = '0;
                        state_d = ST_UPD;
                    end else begin
                        state_d = ST_RD_NXT;
                    end
                end
            end
            ST_RD_NXT: begin
                rd_cnt_d = rd_cnt_q + 3'd1;
                if (rd_last) begin
                    rd_cnt_d = '0;
                    maxv_d   = am_max_nxt;
                    state_d  = ST_UPD;
                end
            end
            ST_UPD: begin
                if (upd_ack) begin
                    newv_d  = upd_new_q;
                    state_d = ST_WR;
                end
            end
            ST_WR: begin
                fact_d   = act_q;
                fstate_d = nxt_q;
                state_d  = ST_CHK;
            end
            ST_CHK: begin
                state_d = ST_RD_CUR;
                if (ep_end) begin
                    step_d = '0;
                    cur_d  = start_q;
                    ep_d   = ep_q + 7'd1;
                    if ((ep_q + 7'd1) == 7'(N_EPISODES)) begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end
                end else begin
                    step_d = step_q + 1'b1;
                    cur_d  = nxt_q;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Sequencer state and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            rd_cnt_q <= '0;
            cur_q    <= '0;
            nxt_q    <= '0;
            start_q  <= '0;
            tgt_q    <= '0;
            fstate_q <= '0;
            act_q    <= '0;
            fact_q   <= '0;
            oldv_q   <= '0;
            maxv_q   <= '0;
            rew_q    <= '0;
            newv_q   <= '0;
            step_q   <= '0;
            ep_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            rd_cnt_q <= rd_cnt_d;
            cur_q    <= cur_d;
            nxt_q    <= nxt_d;
            start_q  <= start_d;
            tgt_q    <= tgt_d;
            fstate_q <= fstate_d;
            act_q    <= act_d;
            fact_q   <= fact_d;
            oldv_q   <= oldv_d;
            maxv_q   <= maxv_d;
            rew_q    <= rew_d;
            newv_q   <= newv_d;
            step_q   <= step_d;
            ep_q     <= ep_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    // RAM address mux: current row, next row, or the write-back entry
    always_comb begin
        q_addr = '0;
        if ((state_q == ST_RD_CUR) && rd_issue) begin
            q_addr = q_learn_pkg::q_addr(cur_q, rd_cnt_q[1:0]);
        end else if ((state_q == ST_RD_NXT) && rd_issue) begin
            q_addr = q_learn_pkg::q_addr(nxt_q, rd_cnt_q[1:0]);
        end else if (state_q == ST_WR) begin
            q_addr = q_learn_pkg::q_addr(cur_q, act_q);
        end
    end

    assign q_rd_en          = rd_issue;
    assign q_wr_en          = (state_q == ST_WR);
    assign q_wdata          = newv_q;
    assign env_req          = (state_q == ST_ENV);
    assign env_state        = cur_q;
    assign env_action       = A_W'(act_q);
    assign upd_req          = (state_q == ST_UPD);
    assign upd_old_q        = oldv_q;
    assign upd_max_q        = maxv_q;
    assign upd_reward       = rew_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign episode_cnt      = ep_q;
    assign final_action     = A_W'(fact_q);
    assign final_maze_state = fstate_q;

endmodule
`default_nettype wire

// File: tb/tb_q_learn_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_q_learn_ctrl
// Description : Self-checking bench for q_learn_ctrl. A RAM model, an
//               environment responder and an update responder surround the
//               DUT; a reference model predicts each step and pushes the
//               expected write-back into a scoreboard queue.
//               Honours Q_LEARN_EXPLORE_EN in its reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_q_learn_ctrl;

    localparam int N_EP  = 2;
    localparam int M_ST  = 4;

    typedef struct {
        logic [7:0]          addr;
        logic signed [31:0]  data;
        logic signed [31:0]  old;
        logic signed [31:0]  mx;
        logic signed [31:0]  rew;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst;
    logic               rdy;
    logic [5:0]         start_state, target_state;
    logic [7:0]         q_addr;
    logic               q_rd_en, q_wr_en;
    logic [31:0]        q_rdata;
    logic [31:0]        q_wdata;
    logic               env_req;
    logic [5:0]         env_state;
    logic [2:0]         env_action;
    logic               env_ack;
    logic [5:0]         env_next_state;
    logic [31:0]        env_reward;
    logic               upd_req;
    logic [31:0]        upd_old_q, upd_max_q, upd_reward;
    logic               upd_ack;
    logic [31:0]        upd_new_q;
    logic               busy, done;
    logic [6:0]         episode_cnt;
    logic [2:0]         final_action;
    logic [5:0]         final_maze_state;

    int errors = 0;
    int checks = 0;

    int env_mode  = 0;   // 0: walk, 1: jump straight to the target
    int env_delay = 0;
    int env_wait  = 0;
    int seed      = 0;
    logic tb_load = 1'b0;

    logic signed [31:0] ram [256];
    logic signed [31:0] mdl [256];
    exp_t exp_q[$];

    // reference-model state
    logic [5:0]  m_cur, m_start, m_tgt;
    int          m_step, m_ep;
    logic [15:0] m_lfsr = 16'hACE1;
    int          step_idx, wr_cnt, rd_cnt, req_len, max_req_len;
    logic [2:0]  first_act;
    logic [5:0]  step5_state, s_state;
    logic [2:0]  s_act;
    bit          env_prev, upd_prev;

    always #5 clk = ~clk;

    q_learn_ctrl #(.N_EPISODES(N_EP), .MAX_STEPS(M_ST)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .start_state(start_state), .target_state(target_state),
        .q_addr(q_addr), .q_rd_en(q_rd_en), .q_wr_en(q_wr_en),
        .q_rdata(q_rdata), .q_wdata(q_wdata),
        .env_req(env_req), .env_state(env_state), .env_action(env_action),
        .env_ack(env_ack), .env_next_state(env_next_state), .env_reward(env_reward),
        .upd_req(upd_req), .upd_old_q(upd_old_q), .upd_max_q(upd_max_q),
        .upd_reward(upd_reward), .upd_ack(upd_ack), .upd_new_q(upd_new_q),
        .busy(busy), .done(done), .episode_cnt(episode_cnt),
        .final_action(final_action), .final_maze_state(final_maze_state)
    );

    task automatic chk(input string tag, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic logic signed [31:0] pat(input int i, input int sd);
        int r = i >> 2;
        int k = i & 3;
        int row5[4] = '{3, 7, 7, -2};
        int row9[4] = '{-5, -1, -9, -3};
        if (r == 5) return 32'(row5[k]);
        if (r == 9) return 32'(row9[k]);
        return 32'(((i * 37 + sd * 53 + 7) % 61) - 30);
    endfunction

    function automatic logic [5:0] env_fn(input logic [5:0] s, input logic [2:0] a,
                                          input int mode, input logic [5:0] tg);
        if (mode == 1) return tg;
        if (a == 3'd3) return s;              // blocked move
        return 6'((int'(s) + int'(a) + 1) % 48);
    endfunction

    function automatic logic signed [31:0] rew_fn(input logic [2:0] a, input int mode);
        if (mode == 1) return 32'sd100;
        return 32'(int'(a) * 5 - 4);
    endfunction

    function automatic logic signed [31:0] upd_fn(input logic signed [31:0] o,
                                                  input logic signed [31:0] r,
                                                  input logic signed [31:0] m,
                                                  input int mode);
        if (mode == 1) return 32'sd50;
        return o + ((r + m - o) >>> 1);
    endfunction

    // environment and update responders
    assign env_ack        = env_req && (env_wait >= env_delay);
    assign env_next_state = env_fn(env_state, env_action, env_mode, target_state);
    assign env_reward     = rew_fn(env_action, env_mode);
    assign upd_ack        = upd_req;
    assign upd_new_q      = upd_fn(upd_old_q, upd_reward, upd_max_q, env_mode);

    always @(posedge clk) begin
        env_wait <= (env_req && !env_ack) ? env_wait + 1 : 0;
    end

    // Q RAM model with one-cycle read latency
    always @(posedge clk) begin
        if (tb_load) begin
            for (int i = 0; i < 256; i++) ram[i] <= pat(i, seed);
        end else begin
            if (q_wr_en) ram[q_addr] <= q_wdata;
            if (q_rd_en) q_rdata <= ram[q_addr];
        end
    end

    // reference model + scoreboard monitor
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                exp_q.delete();
                env_prev = 1'b0;
                upd_prev = 1'b0;
                m_lfsr   = 16'hACE1;
            end else begin
                if (tb_load) for (int i = 0; i < 256; i++) mdl[i] = pat(i, seed);
                if (rdy && !busy) begin
                    m_cur = start_state; m_start = start_state; m_tgt = target_state;
                    m_step = 0; m_ep = 0; step_idx = 0; wr_cnt = 0; rd_cnt = 0;
                    max_req_len = 0; first_act = 3'd7; step5_state = 6'h3f;
                end
                if (q_rd_en) rd_cnt++;
                if (env_req && !env_prev) begin
                    logic [1:0] a;
                    logic signed [31:0] best;
                    exp_t e;
                    logic [5:0] nx;
                    a = 2'd0;
                    best = mdl[{m_cur, 2'd0}];
                    for (int k = 1; k < 4; k++) begin
                        if (mdl[{m_cur, 2'(k)}] > best) begin
                            best = mdl[{m_cur, 2'(k)}];
                            a = 2'(k);
                        end
                    end
`ifdef Q_LEARN_EXPLORE_EN
                    if (m_lfsr[3:0] == 4'd0) a = m_lfsr[5:4];
                    m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
`endif
                    chk("env_state", env_state, m_cur);
                    chk("env_action", env_action, {1'b0, a});
                    step_idx++;
                    if (step_idx == 1) first_act = env_action;
                    if (step_idx == 5) step5_state = env_state;
                    s_state = env_state;
                    s_act   = env_action;
                    req_len = 1;
                    nx      = env_fn(m_cur, {1'b0, a}, env_mode, m_tgt);
                    e.addr  = {m_cur, a};
                    e.old   = mdl[{m_cur, a}];
                    e.rew   = rew_fn({1'b0, a}, env_mode);
                    e.mx    = 32'sd0;
                    if (nx != m_tgt) begin
                        e.mx = mdl[{nx, 2'd0}];
                        for (int k = 1; k < 4; k++)
                            if (mdl[{nx, 2'(k)}] > e.mx) e.mx = mdl[{nx, 2'(k)}];
                    end
                    e.data = upd_fn(e.old, e.rew, e.mx, env_mode);
                    exp_q.push_back(e);
                    mdl[e.addr] = e.data;
                    if (nx == m_tgt || m_step == M_ST - 1) begin
                        m_ep++; m_step = 0; m_cur = m_start;
                    end else begin
                        m_step++; m_cur = nx;
                    end
                end else if (env_req) begin
                    req_len++;
                    chk("stall_state", env_state, s_state);
                    chk("stall_action", env_action, s_act);
                    chk("stall_ram", {q_rd_en, q_wr_en}, 0);
                end
                if (env_req && env_ack && req_len > max_req_len) max_req_len = req_len;
                if (upd_req && !upd_prev) begin
                    if (exp_q.size() == 0) chk("upd_orphan", 1, 0);
                    else begin
                        chk("upd_old_q", $signed(upd_old_q), exp_q[0].old);
                        chk("upd_max_q", $signed(upd_max_q), exp_q[0].mx);
                        chk("upd_reward", $signed(upd_reward), exp_q[0].rew);
                    end
                end
                if (q_wr_en) begin
                    wr_cnt++;
                    if (exp_q.size() == 0) chk("wr_orphan", 1, 0);
                    else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        chk("wr_addr", q_addr, e.addr);
                        chk("wr_data", $signed(q_wdata), e.data);
                    end
                end
                env_prev = env_req;
                upd_prev = upd_req;
            end
        end
    end

    task automatic preload(input int sd);
        seed = sd;
        @(posedge clk); #1 tb_load = 1'b1;
        @(posedge clk); #1 tb_load = 1'b0;
    endtask

    task automatic kick(input logic [5:0] st, input logic [5:0] tg);
        start_state = st;
        target_state = tg;
        @(posedge clk); #1 rdy = 1'b1;
        @(posedge clk); #1 rdy = 1'b0;
    endtask

    task automatic run(input logic [5:0] st, input logic [5:0] tg);
        kick(st, tg);
        for (int i = 0; i < 3000; i++) begin
            if (done) break;
            @(posedge clk); #1;
        end
        chk("run_done", done, 1);
        chk("sb_empty", exp_q.size(), 0);
    endtask

    initial begin
        int nr;
        bit act_seen;
        rst = 1'b0; rdy = 1'b0; start_state = '0; target_state = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_wr", q_wr_en, 0);
        chk("rst_req", {env_req, upd_req, q_rd_en}, 0);
        chk("rst_addr", q_addr, 0);
        chk("rst_ep", episode_cnt, 0);
        rst = 1'b1;

        // greedy with tie, step limit over two episodes
        env_mode = 0; env_delay = 0;
        preload(0);
        run(6'd5, 6'd63);
`ifndef Q_LEARN_EXPLORE_EN
        chk("greedy_tie", first_act, 1);
`endif
        chk("limit_writes", wr_cnt, 8);
        chk("limit_step5", step5_state, 5);
        chk("limit_ep", episode_cnt, 2);
        chk("limit_busy", busy, 0);

        // all-negative row, every step lands on the goal
        env_mode = 1;
        preload(1);
        run(6'd9, 6'd20);
`ifndef Q_LEARN_EXPLORE_EN
        chk("greedy_neg", first_act, 1);
`endif
        chk("goal_writes", wr_cnt, 2);
        chk("goal_reads", rd_cnt, 8);
        chk("goal_ep", episode_cnt, 2);
        chk("goal_fstate", final_maze_state, 20);
        repeat (5) @(posedge clk);
        #1 chk("done_hold", done, 1);

        // environment stall
        env_mode = 0; env_delay = 10;
        preload(2);
        run(6'd12, 6'd63);
        chk("stall_len", max_req_len, 11);
        chk("stall_writes", wr_cnt, 8);
        env_delay = 0;

        // additional random-pattern runs
`ifdef Q_LEARN_EXPLORE_EN
        nr = 25;
`else
        nr = 4;
`endif
        for (int r = 0; r < nr; r++) begin
            preload(3 + r);
            run(6'((5 + r * 7) % 40), 6'd63);
        end

        // reset in the middle of a run
        preload(40);
        kick(6'd5, 6'd63);
        repeat (40) @(posedge clk);
        #3 rst = 1'b0;
        #1;
        chk("mid_busy", busy, 0);
        chk("mid_strobes", {q_rd_en, q_wr_en, env_req, upd_req}, 0);
        chk("mid_ep", episode_cnt, 0);
        chk("mid_addr", q_addr, 0);
        chk("mid_fstate", final_maze_state, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        act_seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (busy || env_req || q_rd_en || q_wr_en) act_seen = 1'b1;
        end
        chk("post_rst_idle", act_seen, 0);
        chk("post_rst_done", done, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/q_learn_ctrl.md
# q_learn_ctrl

Iterative sequencer for the maze Q-learning engine. It replaces fully unrolled, combinational per-episode update chains with one shared update path driven over many clock cycles. Per step it reads the current state's Q row from the shared Q-table RAM, selects an action, queries the maze environment, reads the next state's Q row for max Q, hands operands to the Q-update datapath, and writes the result back. It sits between the Q-table RAM (preloaded by the init/blocked-state logic), the environment/transition block, and the NEW_Q-style update arithmetic.

## Interface
- N_ACTIONS, 4, actions per state; fixed at 4 because the address uses a 2-bit action field
- S_W, 6, maze state width
- A_W, 3, action port width
- Q_W, 32, Q value width, signed two's complement
- N_EPISODES, 100, episodes per run
- MAX_STEPS, 64, step limit per episode
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- rdy  in  1  start pulse; sampled only in IDLE
- start_state / target_state  in  S_W  episode start and goal cells
- q_addr  out  S_W+2  Q RAM address {state, action[1:0]}
- q_rd_en / q_wr_en  out  1  RAM read / write strobes
- q_rdata  in  Q_W  read data, valid 1 cycle after q_rd_en
- q_wdata  out  Q_W  write data
- env_req  out  1;  env_state  out  S_W;  env_action  out  A_W  environment query
- env_ack  in  1;  env_next_state  in  S_W;  env_reward  in  Q_W  environment response
- upd_req  out  1;  upd_old_q / upd_max_q / upd_reward  out  Q_W  update operands
- upd_ack  in  1;  upd_new_q  in  Q_W  updated value
- busy / done  out  1  run active / run complete (level)
- episode_cnt  out  7  completed episodes
- final_action  out  A_W;  final_maze_state  out  S_W  last action taken and last state reached

## Operation
- FSM: IDLE → RD_CUR → ENV → RD_NXT → UPD → WR → CHK → (RD_CUR | DONE).
- IDLE: on rdy, load cur_state = start_state, clear step and episode counters, clear done, set busy.
- RD_CUR: issue reads at a = 0..3 on consecutive cycles. A streaming accumulator forms the signed max and argmax. Ties go to the lowest index. Capture old_q for the chosen action.
- ENV: hold env_req with stable env_state and env_action until env_ack is sampled high. Capture next_state and reward.
- RD_NXT: read 4 entries of next_state and form the signed max.
  - If next_state == target_state, skip this state and set max_q = 0 (terminal).
- UPD: hold upd_req with stable operands until upd_ack. Capture upd_new_q.
- WR: one cycle of q_wr_en at {cur_state, action} with the new value. Update final_action and final_maze_state = next_state.
- CHK:
  - If next_state == target_state or step_cnt == MAX_STEPS-1: episode_cnt++, step_cnt = 0, cur_state = start_state.
  - Otherwise step_cnt++, cur_state = next_state.
  - If episode_cnt reaches N_EPISODES, go to DONE.
- DONE: busy = 0, done = 1, then return to IDLE. done holds until the next accepted rdy.
- A blocked move (env_next_state == env_state) is a normal step: it is updated and does not end the episode.
- rdy while busy is ignored.

## Timing
- Reset values: all strobes and reqs 0, busy 0, done 0, counters 0, final_action 0, final_maze_state 0, q_addr and wdata 0.
- Reset takes effect immediately in any state. An in-flight RAM write or handshake is abandoned. The RAM is not cleared.
- RD phases: 4 issue cycles + 1 drain cycle = 5 cycles.
- Handshake: ack is accepted in any cycle where req is high, including the first req cycle. req drops the next cycle.
- Minimum step with same-cycle acks: 5+1+5+1+1+1 = 14 cycles; 9 cycles when the next state is the target.
- Result is visible on q_wr_en exactly 1 cycle after upd_ack is sampled.

## Configuration
- Q_LEARN_EXPLORE_EN defined: a 16-bit Fibonacci LFSR (seed 16'hACE1, taps 16,14,13,11) steps once per RD_CUR completion.
  - If lfsr[3:0] == 0, action = lfsr[5:4] and old_q = the Q of that action.
  - Otherwise greedy.
- Q_LEARN_EXPLORE_EN undefined: purely greedy and the LFSR is absent.

## Structure
- Package q_learn_pkg holds:
  - the FSM state enum
  - S_W, A_W, Q_W and N_ACTIONS constants
  - a q_addr(state, action) function
- Sub-module q_argmax: the streaming signed max/argmax accumulator with clear, valid and index inputs. It is instantiated once and reused by RD_CUR and RD_NXT.

## Test plan
- Reset (rst=0 mid-run, then release) → all outputs at reset values, no q_wr_en, FSM in IDLE.
- Greedy choice: Q row of state 5 = {3,7,7,-2} → env_action 1. Row {-5,-1,-9,-3} → env_action 1.
- Single step to goal: N_EPISODES=1, env returns target with reward 100, upd_new_q=50 → no RD_NXT reads, upd_max_q=0, one write of 50 at {start,1}, done=1, episode_cnt=1.
- Step limit: MAX_STEPS=4, env never reaches target, N_EPISODES=2 → exactly 8 writes, and env_state equals start_state at the start of step 5.
- Stall: env_ack delayed 10 cycles → env_req, env_state and env_action stable for all 11 cycles, no RAM activity.
- Explore (Q_LEARN_EXPLORE_EN defined) → the action sequence matches the LFSR reference model over 200 steps.
